uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
//
// PURPOSE
// - Buffered front end for uart_tx. Accepts bytes over a valid/ready stream, stores them
//   in a synchronous FIFO and issues them to uart_tx one frame at a time.
// - Drives uart_tx_en/uart_tx_data and monitors uart_tx_busy, so producers never have to
//   pace themselves to the line bit rate. Sits directly upstream of uart_tx; same clock.
//
// PARAMETERS
// - PAYLOAD_BITS  8   data bits per UART frame; must equal uart_tx PAYLOAD_BITS
// - FIFO_DEPTH    16  FIFO entries; power of two, >= 2
//
// PORTS
// - clk           in   1             system clock; all logic on its rising edge
// - reset         in   1             synchronous reset, active high
// - in_data       in   PAYLOAD_BITS  byte to enqueue
// - in_valid      in   1             in_data is valid
// - in_ready      out  1             FIFO can accept; a write occurs when in_valid & in_ready
// - uart_tx_en    out  1             one-cycle launch pulse to uart_tx
// - uart_tx_data  out  PAYLOAD_BITS  byte to uart_tx; stable from launch until the next pop
// - uart_tx_busy  in   1             uart_tx busy flag
// - fifo_empty    out  1             no entries stored
// - fifo_full     out  1             FIFO_DEPTH entries stored
// - tx_idle       out  1             fifo_empty & launcher in IDLE & !uart_tx_busy
//
// BEHAVIOUR
// - Interface: one clock, clk. reset is synchronous and active high.
// - Reset values: uart_tx_en=0, uart_tx_data=0, fifo_empty=1, fifo_full=0, launcher=IDLE.
//   in_ready=0 while reset is high and 1 in the first cycle after. tx_idle=1 once
//   uart_tx_busy is low.
// - FIFO storage:
//   - Read/write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
//   - Count is log2(FIFO_DEPTH)+1 bits. in_ready = !fifo_full, with no bypass when full.
//   - Pushing on the same cycle as a pop leaves the count unchanged.
//   - Write data is never visible to the launcher on the cycle it is written.
// - Launcher FSM:
//   - IDLE: if !fifo_empty & !uart_tx_busy, pop the head entry into uart_tx_data and go to
//     LAUNCH. Otherwise stay in IDLE.
//   - LAUNCH: assert uart_tx_en for exactly this cycle, then go to WAIT_BUSY.
//   - WAIT_BUSY: stay until uart_tx_busy=1, then go to WAIT_DONE.
//   - WAIT_DONE: stay until uart_tx_busy=0, then go to IDLE.
// - Latency:
//   - A write accepted in cycle N into an empty FIFO is popped in cycle N+1.
//   - uart_tx_en is high in cycle N+2.
//   - Back-to-back frames: the next launch comes at least 2 cycles after busy falls
//     (IDLE pop, then LAUNCH).
// - Boundaries:
//   - Full FIFO: in_valid is held and not consumed. No data is lost or overwritten.
//   - Pop from a full FIFO: in_ready rises the next cycle.
//   - Simultaneous pop and push when count=1: the count stays at 1 and the order is kept.
//   - uart_tx_busy already high in IDLE (external or non-reset uart_tx): no launch until
//     it falls.
//   - reset mid-frame:
//     - FIFO contents are discarded and the FSM returns to IDLE. No uart_tx_en pulse is
//       emitted.
//     - If uart_tx is still busy after reset, the launcher waits for busy low.
// - Ordering: strictly FIFO. Each accepted byte produces exactly one uart_tx_en pulse.
//
// CONFIGURATION
// - UART_TX_FIFO_LEVEL_EN defined:
//   - Adds output port fifo_level [log2(FIFO_DEPTH):0], equal to the current entry count.
//   - fifo_level resets to 0 and updates on the same edge as fifo_empty/fifo_full.
// - UART_TX_FIFO_LEVEL_EN undefined: the port and its logic are absent. All other
//   behaviour is identical.
//
// TESTING
// - Single byte: push 0xA5 in cycle N into an empty FIFO, with uart_tx idle
//   -> uart_tx_en=1 only in cycle N+2, uart_tx_data=0xA5, tx_idle=1 after the frame.
// - Burst: push 0x01..0x10 back to back (DEPTH=16) with uart_tx attached
//   -> fifo_full after the 16th push (or 17th if a pop occurred)
//   -> serial output is 0x01..0x10 in order, with exactly 16 en pulses.
// - Backpressure: fill to full, then hold in_valid with 0x55 for 100 cycles
//   -> in_ready=0 and the count stays at 16
//   -> 0x55 is accepted in the cycle after the first pop and is transmitted last.
// - Simultaneous: count=1, push 0x33 on the pop cycle
//   -> count stays 1, and 0x33 is sent as the next frame.
// - Reset mid-frame: 3 bytes queued, assert reset during the 2nd frame's data bits
//   -> fifo_empty=1, uart_tx_en=0, and no further frames after reset.
// - Level (UART_TX_FIFO_LEVEL_EN): push 5 bytes with uart_tx_busy forced high
//   -> fifo_level=5. Release busy -> the level decrements by 1 per frame down to 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered front end for uart_tx.
//
// Accepts bytes on a valid/ready stream, holds them in a synchronous FIFO and hands them to
// uart_tx one frame at a time. It pulses uart_tx_en and then follows uart_tx_busy through
// its rise and fall before it launches the next frame.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous reset, active high
//   in_data       in   byte to enqueue
//   in_valid      in   in_data is valid
//   in_ready      out  FIFO can accept; a write occurs on in_valid & in_ready
//   uart_tx_en    out  one-cycle launch pulse to uart_tx
//   uart_tx_data  out  byte to uart_tx; holds from pop until the next pop
//   uart_tx_busy  in   uart_tx busy flag
//   fifo_empty    out  no entries stored
//   fifo_full     out  FIFO_DEPTH entries stored
//   tx_idle       out  fifo_empty & launcher idle & !uart_tx_busy
//   fifo_level    out  entry count (present only with UART_TX_FIFO_LEVEL_EN defined)
//
// Build option: define UART_TX_FIFO_LEVEL_EN to add the fifo_level output.

module uart_tx_fifo #(
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PAYLOAD_BITS-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    uart_tx_en,
  output logic [PAYLOAD_BITS-1:0] uart_tx_data,
  input  logic                    uart_tx_busy,
  output logic                    fifo_empty,
  output logic                    fifo_full,
  output logic                    tx_idle
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`endif
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLaunch, StWaitBusy, StWaitDone} state_e;

  logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [PAYLOAD_BITS-1:0] r_tx_data;
  state_e                  r_state;
  state_e                  w_state_next;
  logic                    w_push;
  logic                    w_pop;

  // Flags are decoded from the registered count. A byte written this cycle therefore reaches
  // the launcher no earlier than the next cycle.
  assign fifo_empty   = (r_count == '0);
  assign fifo_full    = (r_count == FullCount);
  assign in_ready     = !fifo_full && !reset;
  assign w_push       = in_valid && in_ready;
  assign uart_tx_data = r_tx_data;
  assign tx_idle      = fifo_empty && (r_state == StIdle) && !uart_tx_busy;

`ifdef UART_TX_FIFO_LEVEL_EN
  assign fifo_level = r_count;
`endif

  // Storage needs no reset; entries are only read after they have been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_tx_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_tx_data <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Launcher FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Launcher FSM: next state. The launcher waits for busy to rise and then fall, so a frame
  // that is still running after reset holds off the next launch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (!fifo_empty && !uart_tx_busy) begin
          w_state_next = StLaunch;
        end
      end
      StLaunch: w_state_next = StWaitBusy;
      StWaitBusy: begin
        if (uart_tx_busy) begin
          w_state_next = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!uart_tx_busy) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Launcher FSM: outputs.
  always_comb begin
    w_pop      = 1'b0;
    uart_tx_en = 1'b0;
    unique case (r_state)
      StIdle:   w_pop = !fifo_empty && !uart_tx_busy;
      StLaunch: uart_tx_en = 1'b1;
      default: begin
        w_pop      = 1'b0;
        uart_tx_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. A queue-based reference model is checked against the DUT on
// every clock cycle. Directed scenarios add literal expectations for latency, ordering,
// backpressure and reset. A small uart_tx stand-in raises busy for a fixed frame length
// after each launch.

module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int          FRAME = 20;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] in_data  = 8'h00;
  logic       in_valid = 1'b0;
  logic       busy     = 1'b0;
  logic       in_ready;
  logic       uart_tx_en;
  logic [7:0] uart_tx_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       tx_idle;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [4:0] fifo_level;
`endif

  uart_tx_fifo #(
    .PAYLOAD_BITS(8),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .uart_tx_en  (uart_tx_en),
    .uart_tx_data(uart_tx_data),
    .uart_tx_busy(busy),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .tx_idle     (tx_idle)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .fifo_level  (fifo_level)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic chk_en = 1'b0;
  logic force_busy = 1'b0;
  int   ucnt = 0;
  int   en_count = 0;
  int   last_en_cyc = -1;
  logic [7:0] rx_log[$];

  // Reference model: the stored bytes, the launcher phase and the byte last handed to uart_tx.
  // Phases are 0 idle, 1 launching, 2 waiting for busy, 3 waiting for the frame to end.
  logic [7:0] m_q[$];
  int         m_phase = 0;
  logic [7:0] m_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare, uart_tx stand-in, then model advance. All of these run mid-cycle.
  always @(negedge clk) begin
    logic pop;
    logic push;
    if (chk_en) begin
      check("fifo_empty", {31'd0, fifo_empty}, {31'd0, m_q.size() == 0});
      check("fifo_full", {31'd0, fifo_full}, {31'd0, m_q.size() == DEPTH});
      check("in_ready", {31'd0, in_ready}, {31'd0, (m_q.size() != DEPTH) && !reset});
      check("uart_tx_en", {31'd0, uart_tx_en}, {31'd0, m_phase == 1});
      check("uart_tx_data", {24'd0, uart_tx_data}, {24'd0, m_data});
      check("tx_idle", {31'd0, tx_idle}, {31'd0, (m_q.size() == 0) && (m_phase == 0) && !busy});
`ifdef UART_TX_FIFO_LEVEL_EN
      check("fifo_level", {27'd0, fifo_level}, m_q.size());
`endif
    end
    // uart_tx stand-in: it logs the launched byte and stays busy for FRAME cycles.
    if (uart_tx_en === 1'b1) begin
      rx_log.push_back(uart_tx_data);
      en_count++;
      last_en_cyc = cyc;
      ucnt = FRAME;
    end else if (ucnt > 0) begin
      ucnt--;
    end
    busy = force_busy || (ucnt > 0);
    // The model advances on the values the DUT samples at the next rising edge.
    if (reset) begin
      m_q.delete();
      m_phase = 0;
      m_data  = 8'h00;
    end else begin
      pop  = (m_phase == 0) && (m_q.size() > 0) && !busy;
      push = in_valid && (m_q.size() < DEPTH);
      case (m_phase)
        0: if (pop) begin
          m_data  = m_q.pop_front();
          m_phase = 1;
        end
        1: m_phase = 2;
        2: if (busy) m_phase = 3;
        default: if (!busy) m_phase = 0;
      endcase
      if (push) m_q.push_back(in_data);
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold in_valid until the byte is accepted. acc_cyc is the cycle of the write.
  task automatic push_byte(input logic [7:0] d, output int acc_cyc);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && t < 500) begin
      tick();
      t++;
    end
    if (t >= 500) check("push_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (!(tx_idle === 1'b1 && ucnt == 0) && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) check(name, 32'd0, 32'd1);
  endtask

  task automatic wait_en(input int target, input string name);
    int t;
    t = 0;
    while (en_count < target && t < 3000) begin
      tick();
      t++;
    end
    if (t >= 3000) check(name, 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int e0;
    int acc;

    // Reset
    reset = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_fifo_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_fifo_full", {31'd0, fifo_full}, 32'd0);
    check("rst_tx_en", {31'd0, uart_tx_en}, 32'd0);
    check("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
    check("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single byte: launch two cycles after the write.
    e0 = en_count;
    rx_log.delete();
    push_byte(8'hA5, n);
    wait_idle("single_timeout");
    check("single_en_cycle", last_en_cyc, n + 2);
    check("single_en_count", en_count - e0, 32'd1);
    check("single_data", {24'd0, rx_log[0]}, 32'hA5);
    check("single_idle", {31'd0, tx_idle}, 32'd1);

    // Burst 0x01..0x10 with uart_tx attached.
    e0 = en_count;
    rx_log.delete();
    for (int i = 1; i <= 16; i++) push_byte(8'(i), n);
    wait_idle("burst_timeout");
    check("burst_en_count", en_count - e0, 32'd16);
    check("burst_rx_count", rx_log.size(), 32'd16);
    for (int i = 0; i < 16 && i < rx_log.size(); i++) begin
      check("burst_order", {24'd0, rx_log[i]}, i + 1);
    end

    // Backpressure: busy is held high, the FIFO is filled, and 0x55 waits.
    e0 = en_count;
    rx_log.delete();
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i), n);
    check("bp_full", {31'd0, fifo_full}, 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 100; i++) begin
      if (i % 25 == 0) check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      tick();
    end
    check("bp_still_full", {31'd0, fifo_full}, 32'd1);
    force_busy = 1'b0;
    push_byte(8'h55, acc);
    check("bp_accept_after_pop", acc, last_en_cyc);
    wait_idle("bp_timeout");
    check("bp_en_count", en_count - e0, 32'd17);
    check("bp_first", {24'd0, rx_log[0]}, 32'h20);
    check("bp_last", {24'd0, rx_log[rx_log.size()-1]}, 32'h55);

    // Simultaneous push and pop with one entry stored.
    e0 = en_count;
    rx_log.delete();
    force_busy = 1'b1;
    tick();
    push_byte(8'h11, n);
    tick();
    force_busy = 1'b0;
    in_valid   = 1'b1;
    in_data    = 8'h33;
    check("sim_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("sim_not_empty", {31'd0, fifo_empty}, 32'd0);
    check("sim_launch", {31'd0, uart_tx_en}, 32'd1);
    check("sim_launch_data", {24'd0, uart_tx_data}, 32'h11);
    wait_idle("sim_timeout");
    check("sim_en_count", en_count - e0, 32'd2);
    check("sim_second", {24'd0, rx_log[rx_log.size()-1]}, 32'h33);

    // Reset during the second of three frames.
    e0 = en_count;
    rx_log.delete();
    force_busy = 1'b1;
    tick();
    push_byte(8'hA1, n);
    push_byte(8'hA2, n);
    push_byte(8'hA3, n);
    force_busy = 1'b0;
    wait_en(e0 + 2, "rst_mid_timeout");
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    reset = 1'b0;
    check("rst_mid_empty", {31'd0, fifo_empty}, 32'd1);
    check("rst_mid_en", {31'd0, uart_tx_en}, 32'd0);
    repeat (3 * FRAME) tick();
    check("rst_mid_no_more", en_count - e0, 32'd2);
    check("rst_mid_idle", {31'd0, tx_idle}, 32'd1);

`ifdef UART_TX_FIFO_LEVEL_EN
    // Level: five bytes held by busy, then drained.
    force_busy = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i), n);
    check("level_five", {27'd0, fifo_level}, 32'd5);
    force_busy = 1'b0;
    wait_idle("level_timeout");
    check("level_zero", {27'd0, fifo_level}, 32'd0);
`endif

    repeat (3) tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
